// File: rtl/video_timing_gen.sv
// Raster timing source: hs/vs/de, pixel coordinates, frame/line markers
// and built-in test patterns. All outputs are registered; the values after
// an edge describe the (h,v) position held before that edge.
module video_timing_gen #(
    parameter int   H_WIDTH  = 1920,
    parameter int   H_START  = 2008,
    parameter int   H_SYNC   = 44,
    parameter int   H_TOTAL  = 2200,
    parameter int   V_HEIGHT = 1080,
    parameter int   V_START  = 1084,
    parameter int   V_SYNC   = 5,
    parameter int   V_TOTAL  = 1125,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   KH       = 30,
    parameter int   KV       = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        resync_i,
    input  logic [1:0]  pattern_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [15:0] hx_o,
    output logic [15:0] vy_o,
    output logic        sof_o,
    output logic        eol_o,
    output logic [23:0] data_o
);

    // Window bounds are folded into constants so no runtime sum can overflow.
    localparam logic [15:0] H_LAST_L   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST_L   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_L    = 16'(H_WIDTH);
    localparam logic [15:0] V_ACT_L    = 16'(V_HEIGHT);
    localparam logic [15:0] H_EOL_L    = 16'(H_WIDTH - 1);
    localparam logic [15:0] HS_FIRST_L = 16'(H_START);
    localparam logic [15:0] HS_LAST_L  = 16'(H_START + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST_L = 16'(V_START);
    localparam logic [15:0] VS_LAST_L  = 16'(V_START + V_SYNC - 1);
    localparam logic [15:0] BAR_END_L  = 16'((H_WIDTH / 8) - 1);
    localparam logic [15:0] KH_END_L   = 16'(KH - 1);
    localparam logic [15:0] KV_END_L   = 16'(KV - 1);

    // Colour bar lookup, white through black.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [15:0] h_r, v_r;
    logic [15:0] bar_cnt_r, hk_cnt_r, vk_cnt_r;
    logic [2:0]  bar_idx_r;
    logic        hb_r, vb_r;
    logic [1:0]  pattern_r;

    logic [15:0] h_cur_s, v_cur_s, h_nxt_s, v_nxt_s;
    logic [15:0] bar_cnt_cur_s, hk_cnt_cur_s, vk_cnt_cur_s;
    logic [15:0] bar_cnt_nxt_s, hk_cnt_nxt_s, vk_cnt_nxt_s;
    logic [2:0]  bar_idx_cur_s, bar_idx_nxt_s;
    logic        hb_cur_s, vb_cur_s, hb_nxt_s, vb_nxt_s;
    logic        de_s, sof_s, eol_s, hs_act_s, vs_act_s, line_end_s;
    logic [1:0]  pat_s;
    logic [23:0] pixel_s;

    // Current position (resync forces 0,0), output decode and next-position logic.
    always_comb begin
        h_cur_s = resync_i ? 16'd0 : h_r;
        v_cur_s = resync_i ? 16'd0 : v_r;

        // Pattern counters restart at the left edge / top line.
        if (h_cur_s == 16'd0) begin
            bar_cnt_cur_s = 16'd0;
            bar_idx_cur_s = 3'd0;
            hk_cnt_cur_s  = 16'd0;
            hb_cur_s      = 1'b0;
        end else begin
            bar_cnt_cur_s = bar_cnt_r;
            bar_idx_cur_s = bar_idx_r;
            hk_cnt_cur_s  = hk_cnt_r;
            hb_cur_s      = hb_r;
        end
        if (v_cur_s == 16'd0) begin
            vk_cnt_cur_s = 16'd0;
            vb_cur_s     = 1'b0;
        end else begin
            vk_cnt_cur_s = vk_cnt_r;
            vb_cur_s     = vb_r;
        end

        de_s     = (h_cur_s < H_ACT_L) && (v_cur_s < V_ACT_L);
        sof_s    = de_s && (h_cur_s == 16'd0) && (v_cur_s == 16'd0);
        eol_s    = de_s && (h_cur_s == H_EOL_L);
        hs_act_s = (h_cur_s >= HS_FIRST_L) && (h_cur_s <= HS_LAST_L);
        vs_act_s = (v_cur_s >= VS_FIRST_L) && (v_cur_s <= VS_LAST_L);

        // A new pattern takes effect exactly on the first pixel of a frame.
        pat_s = sof_s ? pattern_i : pattern_r;
        case (pat_s)
            2'b00:   pixel_s = 24'h000000;
            2'b01:   pixel_s = bar_color(bar_idx_cur_s);
            2'b10:   pixel_s = (hb_cur_s ^ vb_cur_s) ? 24'h000000 : 24'hFFFFFF;
            2'b11:   pixel_s = {3{h_cur_s[7:0]}};
            default: pixel_s = 24'h000000;
        endcase
        if (!de_s) begin
            pixel_s = 24'h000000;
        end else begin
            pixel_s = pixel_s;
        end

        line_end_s = (h_cur_s == H_LAST_L);
        if (line_end_s) begin
            h_nxt_s = 16'd0;
            v_nxt_s = (v_cur_s == V_LAST_L) ? 16'd0 : v_cur_s + 16'd1;
        end else begin
            h_nxt_s = h_cur_s + 16'd1;
            v_nxt_s = v_cur_s;
        end

        // Last bar absorbs the remainder, so the bar counter parks at index 7.
        if (bar_idx_cur_s == 3'd7) begin
            bar_idx_nxt_s = bar_idx_cur_s;
            bar_cnt_nxt_s = bar_cnt_cur_s;
        end else if (bar_cnt_cur_s == BAR_END_L) begin
            bar_idx_nxt_s = bar_idx_cur_s + 3'd1;
            bar_cnt_nxt_s = 16'd0;
        end else begin
            bar_idx_nxt_s = bar_idx_cur_s;
            bar_cnt_nxt_s = bar_cnt_cur_s + 16'd1;
        end

        if (hk_cnt_cur_s == KH_END_L) begin
            hk_cnt_nxt_s = 16'd0;
            hb_nxt_s     = ~hb_cur_s;
        end else begin
            hk_cnt_nxt_s = hk_cnt_cur_s + 16'd1;
            hb_nxt_s     = hb_cur_s;
        end

        // Vertical block counter advances once per line.
        if (!line_end_s) begin
            vk_cnt_nxt_s = vk_cnt_r;
            vb_nxt_s     = vb_r;
        end else if (vk_cnt_cur_s == KV_END_L) begin
            vk_cnt_nxt_s = 16'd0;
            vb_nxt_s     = ~vb_cur_s;
        end else begin
            vk_cnt_nxt_s = vk_cnt_cur_s + 16'd1;
            vb_nxt_s     = vb_cur_s;
        end
    end

    // Raster state and registered outputs; disable freezes position and blanks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_r       <= 16'd0;
            v_r       <= 16'd0;
            bar_cnt_r <= 16'd0;
            bar_idx_r <= 3'd0;
            hk_cnt_r  <= 16'd0;
            hb_r      <= 1'b0;
            vk_cnt_r  <= 16'd0;
            vb_r      <= 1'b0;
            pattern_r <= 2'b00;
            hs_o      <= ~HS_POL;
            vs_o      <= ~VS_POL;
            de_o      <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            hx_o      <= 16'd0;
            vy_o      <= 16'd0;
            data_o    <= 24'd0;
        end else if (en_i) begin
            h_r       <= h_nxt_s;
            v_r       <= v_nxt_s;
            bar_cnt_r <= bar_cnt_nxt_s;
            bar_idx_r <= bar_idx_nxt_s;
            hk_cnt_r  <= hk_cnt_nxt_s;
            hb_r      <= hb_nxt_s;
            vk_cnt_r  <= vk_cnt_nxt_s;
            vb_r      <= vb_nxt_s;
            pattern_r <= pat_s;
            hs_o      <= hs_act_s ? HS_POL : ~HS_POL;
            vs_o      <= vs_act_s ? VS_POL : ~VS_POL;
            de_o      <= de_s;
            sof_o     <= sof_s;
            eol_o     <= eol_s;
            hx_o      <= h_cur_s;
            vy_o      <= v_cur_s;
            data_o    <= pixel_s;
        end else begin
            h_r       <= resync_i ? 16'd0 : h_r;
            v_r       <= resync_i ? 16'd0 : v_r;
            hs_o      <= ~HS_POL;
            vs_o      <= ~VS_POL;
            de_o      <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            data_o    <= 24'd0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen with a frame-position reference model.
module tb_video_timing_gen;

    localparam int HW = 8, HST = 10, HSY = 1, HT = 12;
    localparam int VH = 4, VST = 5, VSY = 1, VT = 6;
    localparam int KH = 2, KV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        resync = 1'b0;
    logic [1:0]  pattern = 2'b00;
    logic        hs, vs, de, sof, eol;
    logic [15:0] hx, vy;
    logic [23:0] data;

    int total = 0;
    int bad = 0;

    // model state: frame position and active pattern
    int          mh, mv;
    logic [1:0]  mpat;
    logic        e_hs, e_vs, e_de, e_sof, e_eol;
    int          e_hx, e_vy;
    logic [23:0] e_data;

    video_timing_gen #(
        .H_WIDTH(HW), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HT),
        .V_HEIGHT(VH), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VT),
        .HS_POL(1'b1), .VS_POL(1'b1), .KH(KH), .KV(KV)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(resync), .pattern_i(pattern),
        .hs_o(hs), .vs_o(vs), .de_o(de), .hx_o(hx), .vy_o(vy),
        .sof_o(sof), .eol_o(eol), .data_o(data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mpat = 2'b00;
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0;
        e_hx = 0; e_vy = 0; e_data = 24'd0;
    endtask

    // one clock edge of the reference: outputs describe the position before the edge
    task automatic model_edge(input logic m_en, input logic m_rs, input logic [1:0] m_pat);
        int he, ve, pos, bi;
        if (m_en) begin
            he = m_rs ? 0 : mh;
            ve = m_rs ? 0 : mv;
            e_de  = (he < HW) && (ve < VH);
            e_sof = e_de && he == 0 && ve == 0;
            e_eol = e_de && he == HW - 1;
            e_hs  = (he >= HST) && (he < HST + HSY);
            e_vs  = (ve >= VST) && (ve < VST + VSY);
            if (e_sof) mpat = m_pat;
            e_hx = he;
            e_vy = ve;
            bi = he / (HW / 8);
            if (bi > 7) bi = 7;
            if (!e_de)             e_data = 24'd0;
            else if (mpat == 2'd0) e_data = 24'd0;
            else if (mpat == 2'd1) e_data = bar_rgb(bi);
            else if (mpat == 2'd2) e_data = (((he / KH) + (ve / KV)) % 2 == 0) ? 24'hFFFFFF : 24'd0;
            else                   e_data = {3{8'(he)}};
            pos = (ve * HT + he + 1) % (HT * VT);
            mh = pos % HT;
            mv = pos / HT;
        end else begin
            if (m_rs) begin
                mh = 0; mv = 0;
            end
            e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0;
            e_data = 24'd0;
        end
    endtask

    task automatic compare_all();
        check("hs", 32'(hs), 32'(e_hs));
        check("vs", 32'(vs), 32'(e_vs));
        check("de", 32'(de), 32'(e_de));
        check("sof", 32'(sof), 32'(e_sof));
        check("eol", 32'(eol), 32'(e_eol));
        check("hx", 32'(hx), 32'(e_hx));
        check("vy", 32'(vy), 32'(e_vy));
        check("data", 32'(data), 32'(e_data));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hs"}, 32'(hs), 32'd0);
        check({tag, "_vs"}, 32'(vs), 32'd0);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_sof"}, 32'(sof), 32'd0);
        check({tag, "_eol"}, 32'(eol), 32'd0);
        check({tag, "_hx"}, 32'(hx), 32'd0);
        check({tag, "_vy"}, 32'(vy), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
    endtask

    task automatic step(input logic s_en, input logic s_rs, input logic [1:0] s_pat);
        en = s_en; resync = s_rs; pattern = s_pat;
        @(posedge clk);
        #1;
        model_edge(s_en, s_rs, s_pat);
        compare_all();
        resync = 1'b0;
    endtask

    task automatic run_until(input int th, input int tv, input logic [1:0] s_pat);
        int n = 0;
        while (!(mh == th && mv == tv) && n < 200) begin
            step(1'b1, 1'b0, s_pat);
            n++;
        end
        check("reach_pos", 32'(mh == th && mv == tv), 32'd1);
    endtask

    initial begin
        int n_vs, n_hs, n_sof, n_eol;
        logic r_en, r_rs;
        logic [1:0] r_pat;

        model_reset();
        #2 rst = 1'b1;
        #1 check_reset("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // two full frames from reset: sync/marker counts
        n_vs = 0; n_hs = 0; n_sof = 0; n_eol = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b1, 1'b0, 2'b00);
            if (i == 0) check("first_sof", 32'(sof), 32'd1);
            if (i == HW - 1) check("first_eol", 32'(eol), 32'd1);
            if (i == HST) check("first_hs", 32'(hs), 32'd1);
            n_vs += int'(vs); n_hs += int'(hs); n_sof += int'(sof); n_eol += int'(eol);
        end
        check("vs_cycles", 32'(n_vs), 32'(2 * HT * VSY));
        check("hs_cycles", 32'(n_hs), 32'(2 * VT * HSY));
        check("sof_count", 32'(n_sof), 32'd2);
        check("eol_count", 32'(n_eol), 32'(2 * VH));

        // checkerboard then bars, one frame plus each
        for (int i = 0; i < HT * VT + 5; i++) step(1'b1, 1'b0, 2'b10);
        for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, 2'b01);

        // pattern change mid-frame: black -> ramp at line 2
        run_until(0, 0, 2'b00);
        run_until(0, 2, 2'b00);
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b0, 2'b11);

        // resync pulse at (5,3)
        run_until(5, 3, 2'b11);
        step(1'b1, 1'b1, 2'b11);
        check("resync_sof", 32'(sof), 32'd1);
        check("resync_hx", 32'(hx), 32'd0);
        for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, 2'b11);
        check("resync_period", 32'(sof), 32'd1);

        // enable low for 20 cycles at (3,1)
        run_until(3, 1, 2'b10);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'b10);
        check("dis_de", 32'(de), 32'd0);
        step(1'b1, 1'b0, 2'b10);
        check("resume_hx", 32'(hx), 32'd3);
        check("resume_vy", 32'(vy), 32'd1);

        // randomised traffic with one asynchronous reset mid-line
        r_pat = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) r_pat = 2'($urandom_range(0, 3));
            r_en = ($urandom_range(0, 7) != 0);
            r_rs = ($urandom_range(0, 63) == 0);
            step(r_en, r_rs, r_pat);
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1 check_reset("rst_async");
                model_reset();
                #2 rst = 1'b0;
                for (int k = 0; k < HT; k++) begin
                    step(1'b1, 1'b0, r_pat);
                    if (k == 0) check("restart_sof", 32'(sof), 32'd1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
